// File: rtl/serializer_pkg.sv
// Shared types for the SerDes transmit serializer: default word width,
// word type and the two-state shift FSM encoding.
package serializer_pkg;

    localparam int SER_WIDTH = 16;

    typedef logic [SER_WIDTH-1:0] ser_word_t;

    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/serializer16.sv
// Parallel-to-serial converter: captures a word on load and shifts it out
// MSB-first, one registered bit per clock, with a matching valid/busy flag.
module serializer16
    import serializer_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pdata,
    input  logic             load,
    output logic             sdata,
    output logic             sdata_valid,
    output logic             busy
);

    logic [WIDTH-1:0] shreg_r;
    logic [WIDTH-1:0] shreg_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             sdata_r;
    logic             sdata_s;
    logic             valid_r;
    logic             valid_s;
    ser_state_t       state_s;

    // State register: shift word, remaining-bit counter and output flops
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_r <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            sdata_r <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            shreg_r <= shreg_s;
            cnt_r   <= cnt_s;
            sdata_r <= sdata_s;
            valid_r <= valid_s;
        end
    end

    // Decode FSM state from the counter: zero bits remaining means idle
    always_comb begin
        if (cnt_r != {CNT_W{1'b0}}) begin
            state_s = SER_SHIFT;
        end else begin
            state_s = SER_IDLE;
        end
    end

    // Next-state logic; a load always wins and restarts the word at its MSB
    always_comb begin
        shreg_s = shreg_r;
        cnt_s   = cnt_r;
        sdata_s = 1'b0;
        valid_s = 1'b0;
        if (load) begin
            shreg_s = pdata;
            cnt_s   = CNT_W'(WIDTH);
            sdata_s = pdata[WIDTH-1];
            valid_s = 1'b1;
        end else begin
            case (state_s)
                SER_IDLE: begin
                    shreg_s = {WIDTH{1'b0}};
                    cnt_s   = {CNT_W{1'b0}};
                end
                SER_SHIFT: begin
                    // cnt_r == 1 means bit 0 has just had its cycle on the line
                    if (cnt_r > CNT_W'(1)) begin
                        shreg_s = shreg_r << 1'b1;
                        cnt_s   = cnt_r - CNT_W'(1);
                        sdata_s = shreg_r[WIDTH-2];
                        valid_s = 1'b1;
                    end else begin
                        shreg_s = {WIDTH{1'b0}};
                        cnt_s   = {CNT_W{1'b0}};
                    end
                end
                default: begin
                    shreg_s = {WIDTH{1'b0}};
                    cnt_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Outputs come straight from flops; busy mirrors valid
    always_comb begin
        sdata       = sdata_r;
        sdata_valid = valid_r;
        busy        = valid_r;
    end

endmodule

// File: tb/tb_serializer16.sv
// Self-checking bench for serializer16: each load pushes the expected
// serial sequence to a queue, which is popped and compared every cycle.
module tb_serializer16;
    import serializer_pkg::*;

    logic      clk;
    logic      reset;
    ser_word_t pdata;
    logic      load;
    logic      sdata;
    logic      sdata_valid;
    logic      busy;

    int        n_checks;
    int        n_fail;
    logic [2:0] exp_q[$];

    serializer16 dut (
        .clk        (clk),
        .reset      (reset),
        .pdata      (pdata),
        .load       (load),
        .sdata      (sdata),
        .sdata_valid(sdata_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got {busy,valid,sdata}=%b required %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, update the scoreboard, then check after the edge.
    task automatic drive(input string tag, input logic rst, input logic ld, input ser_word_t pd);
        logic [2:0] exp;
        reset = rst;
        load  = ld;
        pdata = pd;
        if (rst) begin
            exp_q.delete();
        end else if (ld) begin
            exp_q.delete();
            for (int i = SER_WIDTH - 1; i >= 0; i--) begin
                exp_q.push_back({1'b1, 1'b1, pd[i]});
            end
        end
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        else exp = 3'b000;
        check_val(tag, {busy, sdata_valid, sdata}, exp);
    endtask

    task automatic idle_cycles(input string tag, input int n, input ser_word_t pd);
        for (int i = 0; i < n; i++) drive(tag, 1'b0, 1'b0, pd);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        load     = 1'b1;
        pdata    = 16'hFFFF;
        #2;

        drive("reset", 1'b1, 1'b1, 16'hFFFF);
        drive("reset", 1'b1, 1'b1, 16'hFFFF);
        idle_cycles("post_reset_idle", 3, 16'hFFFF);

        drive("word_a5a5", 1'b0, 1'b1, 16'hA5A5);
        idle_cycles("word_a5a5", 15, 16'h0000);
        idle_cycles("end_of_word", 2, 16'h0000);

        idle_cycles("idle_gap", 20, 16'h1234);
        drive("word_3c3c", 1'b0, 1'b1, 16'h3C3C);
        idle_cycles("word_3c3c", 15, 16'hFFFF);
        idle_cycles("end_of_word", 2, 16'h0000);

        drive("restart_old", 1'b0, 1'b1, 16'hA5A5);
        idle_cycles("restart_old", 4, 16'h0000);
        drive("restart_new", 1'b0, 1'b1, 16'h3C3C);
        idle_cycles("restart_new", 15, 16'h0000);
        idle_cycles("end_of_word", 2, 16'h0000);

        drive("ext_load", 1'b0, 1'b1, 16'h8001);
        drive("ext_load", 1'b0, 1'b1, 16'h8001);
        drive("ext_load", 1'b0, 1'b1, 16'h8001);
        idle_cycles("ext_load_tail", 15, 16'h0000);
        idle_cycles("end_of_word", 2, 16'h0000);

        drive("reset_mid", 1'b0, 1'b1, 16'hFFFF);
        idle_cycles("reset_mid", 6, 16'h0000);
        drive("reset_mid_abort", 1'b1, 1'b0, 16'h0000);
        idle_cycles("reset_mid_after", 20, 16'h0000);

        // Random words with random gaps and occasional restarts
        for (int w = 0; w < 8; w++) begin
            ser_word_t rw;
            int        len;
            rw  = ser_word_t'($urandom());
            len = $urandom_range(20, 3);
            drive("rand_load", 1'b0, 1'b1, rw);
            idle_cycles("rand_shift", len, ser_word_t'($urandom()));
        end
        idle_cycles("rand_drain", 18, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
